sevseg_led_driver: RTL and testbench

SEVSEG_LED_DRIVER -- requirements
Module: sevseg_led_driver

---
 rtl/sevseg_led_driver.sv | 133 +++++++++++++
 tb/tb_sevseg_led_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_led_driver.sv
// Six-digit hex 7-segment and LED driver: inputs are shadowed once per PWM frame,
// then decoded with brightness PWM, whole-display blinking and leading-zero blanking.
module sevseg_led_driver #(
    parameter int PRESCALE     = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sevseg0,
    input  logic [3:0] sevseg1,
    input  logic [3:0] sevseg2,
    input  logic [3:0] sevseg3,
    input  logic [3:0] sevseg4,
    input  logic [3:0] sevseg5,
    input  logic [9:0] leds_in,
    input  logic [3:0] brightness,
    input  logic       blink_en,
    input  logic       lz_en,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [9:0] leds,
    output logic       frame_start
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [PS_W-1:0] prescale;
    logic [3:0]      pwm_cnt;
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;
    logic            step;
    logic            frame_end;

    logic [23:0] sh_digs;
    logic [9:0]  sh_leds;
    logic [3:0]  sh_bright;
    logic        sh_blink;
    logic        sh_lz;

    logic        display_on;
    logic [41:0] hex_next;
    logic [41:0] hex_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign step       = (prescale == PS_LAST);
    assign frame_end  = step && (pwm_cnt == 4'hF);
    assign display_on = (sh_bright == 4'hF) || (pwm_cnt < sh_bright);

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        hex_next = {6{7'h7F}};
        for (int k = 0; k < 6; k++) begin
            if (display_on && !(sh_blink && blink_phase) &&
                !(sh_lz && (k != 0) && ((sh_digs >> (4 * k)) == 24'd0)))
                hex_next[7*k +: 7] = seg_decode(sh_digs[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale    <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_digs     <= '0;
            sh_leds     <= '0;
            sh_bright   <= '0;
            sh_blink    <= 1'b0;
            sh_lz       <= 1'b0;
            hex_q       <= {6{7'h7F}};
            leds        <= '0;
            frame_start <= 1'b0;
        end else begin
            prescale <= step ? '0 : prescale + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 4'd1;
            if (frame_end) begin
                sh_digs   <= {sevseg5, sevseg4, sevseg3, sevseg2, sevseg1, sevseg0};
                sh_leds   <= leds_in;
                sh_bright <= brightness;
                sh_blink  <= blink_en;
                sh_lz     <= lz_en;
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            frame_start <= frame_end;
            hex_q       <= hex_next;
            leds        <= display_on ? sh_leds : '0;
        end
    end

    assign hex0 = hex_q[6:0];
    assign hex1 = hex_q[13:7];
    assign hex2 = hex_q[20:14];
    assign hex3 = hex_q[27:21];
    assign hex4 = hex_q[34:28];
    assign hex5 = hex_q[41:35];

endmodule

// File: tb/tb_sevseg_led_driver.sv
// Bench for sevseg_led_driver: cycle-count based reference model checked every cycle,
// a digit/blanking vector table, and directed PWM, hold, blink and reset sequences.
module tb_sevseg_led_driver;
    localparam int PRESCALE     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = 16 * PRESCALE;
    localparam logic [41:0] ALL_DARK = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] digs;
    logic [9:0]  leds_in;
    logic [3:0]  brightness;
    logic        blink_en;
    logic        lz_en;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  leds;
    logic        frame_start;
    logic [41:0] hex_all;

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    sevseg_led_driver #(.PRESCALE(PRESCALE), .BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk(clk), .rst_n(rst_n),
        .sevseg0(digs[3:0]), .sevseg1(digs[7:4]), .sevseg2(digs[11:8]),
        .sevseg3(digs[15:12]), .sevseg4(digs[19:16]), .sevseg5(digs[23:20]),
        .leds_in(leds_in), .brightness(brightness), .blink_en(blink_en), .lz_en(lz_en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .leds(leds), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] digs;
        logic [9:0]  leds;
        logic [3:0]  bright;
        logic        blink;
        logic        lz;
    } shadow_t;

    typedef struct {
        string       name;
        logic [23:0] digs;
        logic        lz;
        logic [41:0] exp_hex;
    } vec_t;

    shadow_t    m_sh;
    int         n;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [6:0] seg_tab [16];

    function automatic logic [41:0] model_hex(input shadow_t s, input int pwm, input int phase);
        logic [41:0] r;
        logic        on;
        logic        blank;
        on = (s.bright == 4'd15) || (pwm < int'(s.bright));
        for (int k = 0; k < 6; k++) begin
            blank = !on || (s.blink && phase == 1) ||
                    (s.lz && k > 0 && (s.digs >> (4 * k)) == 24'd0);
            r[7*k +: 7] = blank ? 7'h7F : seg_tab[s.digs[4*k +: 4]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state before each edge is a pure function of edges since reset release.
    task automatic tick();
        int          pwm;
        int          phase;
        logic [41:0] eh;
        logic [9:0]  el;
        logic        ef;
        @(posedge clk);
        pwm   = (n / PRESCALE) % 16;
        phase = ((n / FRAME) / BLINK_FRAMES) % 2;
        eh    = model_hex(m_sh, pwm, phase);
        el    = (m_sh.bright == 4'd15 || pwm < int'(m_sh.bright)) ? m_sh.leds : 10'd0;
        ef    = ((n % FRAME) == FRAME - 1);
        if (ef)
            m_sh = {digs, leds_in, brightness, blink_en, lz_en};
        n++;
        @(negedge clk);
        check("model", 64'({hex_all, leds, frame_start}), 64'({eh, el, ef}));
    endtask

    task automatic wait_fs(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!frame_start && cyc < 4 * FRAME);
        if (!frame_start) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_start_timeout: none in %0d cycles, required within %0d", cyc, FRAME);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        n     = 0;
        m_sh  = '0;
    endtask

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt_on;
        int bad;
        int cnt_blank;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{"digits_0_5", 24'h543210, 1'b0, {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};
        vecs[1] = '{"lz_001007", 24'h001007, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h78}};
        vecs[2] = '{"lz_all_zero", 24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{"zero_no_lz", 24'h000000, 1'b0, {6{7'h40}}};
        vecs[4] = '{"digits_6_b", 24'h6789AB, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[5] = '{"lz_inner_zero", 24'hFEDC00, 1'b1, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h40, 7'h40}};
        vecs[6] = '{"lz_digit1", 24'h000010, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}};
        vecs[7] = '{"lz_top_only", 24'h100000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        rst_n = 1'b1; digs = 24'h543210; leds_in = 10'h000; brightness = 4'd15;
        blink_en = 1'b0; lz_en = 1'b0;
        n = 0; m_sh = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_hex", 64'(hex_all), 64'(ALL_DARK));
        check("reset_leds", 64'(leds), 64'd0);
        check("reset_fs", 64'(frame_start), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", 64'({hex_all, leds, frame_start}), 64'({ALL_DARK, 10'd0, 1'b0}));
        release_reset();

        // Dark until the first snapshot, then the six digits appear.
        wait_fs(cyc);
        check("first_fs_latency", 64'(cyc), 64'(FRAME));
        check("dark_at_first_fs", 64'(hex_all), 64'(ALL_DARK));
        tick();
        check("first_digits", 64'(hex_all), 64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));

        foreach (vecs[i]) begin
            digs = vecs[i].digs; lz_en = vecs[i].lz; brightness = 4'd15; blink_en = 1'b0;
            wait_fs(cyc);
            tick();
            check(vecs[i].name, 64'(hex_all), 64'(vecs[i].exp_hex));
        end

        // Brightness 4: on for the first 4 PWM steps of each frame.
        brightness = 4'd4; leds_in = 10'h3FF; lz_en = 1'b0; digs = 24'h000123;
        wait_fs(cyc);
        cnt_on = 0; bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (leds == 10'h3FF) cnt_on++;
            if ((leds == 10'h3FF) != (i < 8)) bad++;
        end
        check("pwm_on_cycles", 64'(cnt_on), 64'd8);
        check("pwm_on_window", 64'(bad), 64'd0);

        // A mid-frame input change only shows after the next snapshot.
        brightness = 4'd15; digs = 24'h000008;
        wait_fs(cyc);
        tick();
        check("hold_before", 64'(hex0), 64'h00);
        for (int i = 0; i < 9; i++) tick();
        digs = 24'h00000F;
        bad = 0; cyc = 0;
        do begin
            tick();
            cyc++;
            if (hex0 !== 7'h00) bad++;
        end while (!frame_start && cyc < 4 * FRAME);
        check("hold_old_digit", 64'(bad), 64'd0);
        check("hold_fs_seen", 64'(frame_start), 64'd1);
        tick();
        check("new_digit", 64'(hex0), 64'h0E);

        // Blink: digits blank half the time, LEDs steady.
        blink_en = 1'b1; leds_in = 10'h2A5; digs = 24'h000008;
        wait_fs(cyc);
        cnt_on = 0; cnt_blank = 0; bad = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (leds == 10'h2A5) cnt_on++;
            if (hex0 == 7'h7F) cnt_blank++;
            else if (hex0 != 7'h00) bad++;
        end
        check("blink_leds_steady", 64'(cnt_on), 64'(4 * FRAME));
        check("blink_blank_cycles", 64'(cnt_blank), 64'(2 * FRAME));
        check("blink_digit_value", 64'(bad), 64'd0);
        blink_en = 1'b0;

        // Asynchronous reset mid-frame.
        digs = 24'h543210; leds_in = 10'h3FF; brightness = 4'd15;
        wait_fs(cyc);
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_lit", 64'(leds), 64'h3FF);
        rst_n = 1'b0;
        #1;
        check("async_reset_dark", 64'({hex_all, leds, frame_start}), 64'({ALL_DARK, 10'd0, 1'b0}));
        @(negedge clk);
        @(negedge clk);
        release_reset();
        wait_fs(cyc);
        check("fs_after_reset", 64'(cyc), 64'(FRAME));

        // Randomized inputs against the reference model.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(7) == 0) begin
                digs = 24'($urandom);
                case ($urandom_range(3))
                    0: digs[23:12] = 12'h000;
                    1: digs[23:4]  = 20'h00000;
                    default: ;
                endcase
                leds_in    = 10'($urandom);
                brightness = 4'($urandom);
                blink_en   = 1'($urandom);
                lz_en      = 1'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
